ram32x8_ctrl: RTL

Arbiter and clear sequencer for the 32x8 distributed RAM built from RAM32X1 primitives (ram_32x8). It shares the single RAM port between two requesters (round-robin) and provides a hardware sweep that writes CLR_VAL to all 32 words. It sits directly in front of one ram_32x8 instance and owns its we/d/a pins; the RAM output o returns to this block.

---
 rtl/ram32x8_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/ram32x8_ctrl.sv
// Round-robin port arbiter and clear sequencer in front of a 32x8 distributed RAM.
// The block owns the RAM pins: one access takes two cycles (IDLE grant, then ACC), and a clear writes every word once.
module ram32x8_ctrl #(
  parameter int              AW      = 5,
  parameter int              DW      = 8,
  parameter logic [DW-1:0]   CLR_VAL = '0
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr_req,
  output logic          clr_busy,
  input  logic          req0,
  input  logic          we0,
  input  logic [AW-1:0] a0,
  input  logic [DW-1:0] d0,
  output logic          gnt0,
  output logic [DW-1:0] q0,
  output logic          qv0,
  input  logic          req1,
  input  logic          we1,
  input  logic [AW-1:0] a1,
  input  logic [DW-1:0] d1,
  output logic          gnt1,
  output logic [DW-1:0] q1,
  output logic          qv1,
  output logic          ram_we,
  output logic [AW-1:0] ram_a,
  output logic [DW-1:0] ram_d,
  input  logic [DW-1:0] ram_o
);

  typedef enum logic [1:0] {IDLE, ACC, CLR} state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t state, state_nxt;
  logic   clr_pend;
  logic   last;   // requester served most recently
  logic   sel;    // requester that would win this cycle
  logic   sel_q;  // requester owning the access in ACC

  assign clr_busy = clr_pend;

  // NOTE: every output of this block gets a default first, so no path leaves
  // a variable unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    if (req0 && req1) sel = ~last;
    else              sel = req1;
    case (state)
      IDLE: begin
        if (clr_pend) begin
          state_nxt = CLR;
        end else if (req0 || req1) begin
          state_nxt = ACC;
          gnt0      = ~sel;
          gnt1      = sel;
        end
      end
      ACC:     state_nxt = IDLE;
      CLR:     if (ram_a == LAST_ADDR) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (rst) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ram_we   <= 1'b0;
      ram_a    <= '0;
      ram_d    <= '0;
      q0       <= '0;
      q1       <= '0;
      qv0      <= 1'b0;
      qv1      <= 1'b0;
      clr_pend <= 1'b0;
      last     <= 1'b1;
      sel_q    <= 1'b0;
    end else begin
      qv0 <= 1'b0;
      qv1 <= 1'b0;
      // A clear request arriving while one is already pending or running is dropped.
      if (clr_req && !clr_pend && state != CLR) clr_pend <= 1'b1;
      case (state)
        IDLE: begin
          if (clr_pend) begin
            ram_we <= 1'b1;
            ram_a  <= '0;
            ram_d  <= CLR_VAL;
          end else if (req0 || req1) begin
            ram_we <= sel ? we1 : we0;
            ram_a  <= sel ? a1  : a0;
            ram_d  <= sel ? d1  : d0;
            sel_q  <= sel;
            last   <= sel;
          end
        end
        ACC: begin
          ram_we <= 1'b0;
          if (!ram_we) begin
            if (sel_q) begin
              q1  <= ram_o;
              qv1 <= 1'b1;
            end else begin
              q0  <= ram_o;
              qv0 <= 1'b1;
            end
          end
        end
        CLR: begin
          if (ram_a == LAST_ADDR) begin
            ram_we   <= 1'b0;
            clr_pend <= 1'b0;
          end else begin
            ram_a <= ram_a + 1'b1;
          end
        end
        default: ram_we <= 1'b0;
      endcase
    end
  end

endmodule
